// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from fifo_top and sends each one as an 8N1 UART frame.
// Latency: a start condition sampled at edge k pulses fifo_rd over k..k+1; tx falls at k+2.
// Backpressure: a pop only happens from IDLE with tx_en high and fifo_empty low; frames in flight always finish.
//
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   tx_en               - allows new frames to start (sampled only in IDLE)
//   fifo_empty          - fifo_top empty flag (sampled only in IDLE)
//   fifo_data           - fifo_top read data, valid the cycle after fifo_rd
//   fifo_rd             - registered one-cycle pop strobe to fifo_top
//   tx                  - serial line, idles high
//   busy                - high whenever a frame is being fetched or sent
//   tx_done             - one-cycle pulse after the stop bit ends
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic                  rd_next;
  logic                  done_next;
  logic                  tx_next;
  logic                  bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign busy    = (state != IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    rd_next    = 1'b0;
    done_next  = 1'b0;
    tx_next    = 1'b1;

    case (state)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_next = FETCH;
          rd_next    = 1'b1;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        // fifo_top presents the popped word during this cycle
        shift_next = fifo_data;
        cnt_next   = '0;
        idx_next   = '0;
        state_next = START;
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift >> 1;
          if (idx == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // tx is registered from the next state so the line never glitches
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      shift   <= shift_next;
      fifo_rd <= rd_next;
      tx_done <= done_next;
      tx      <= tx_next;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized and directed stimulus for fifo_uart_tx against a frame-timeline model.
// Latency: model predicts outputs from the number of edges since the start condition.
// Backpressure: a queue-based FIFO model answers fifo_rd; tx_en is toggled to stall new frames.
module tb_fifo_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 2 + 10 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, tx, busy, tx_done;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- FIFO model ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];   // bytes the reference model will send, in order
  logic [7:0] sent_q[$];  // scoreboard for the random phase
  logic [7:0] dec_q[$];   // bytes decoded off the serial line

  int rd_cnt = 0, done_cnt = 0;
  int rd_cyc[$], done_cyc[$];
  int cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fifo_rd) begin
      chk("rd_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
      rd_cnt++;
      rd_cyc.push_back(cyc);
    end
    if (tx_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  // m_t = edges elapsed since the start condition; -1 means idle.
  int         m_t = -1;
  logic [7:0] m_byte = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) m_t = -1;
    else if (m_t < 0 || m_t == FRAME) begin
      if (tx_en && !fifo_empty) begin
        m_t = 0;
        m_byte = exp_q.pop_front();
      end else begin
        m_t = -1;
      end
    end else begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    logic e_tx, e_busy, e_rd, e_done;
    int b;
    e_tx = 1'b1; e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
    if (m_t == FRAME) begin
      e_done = 1'b1;
    end else if (m_t >= 0) begin
      e_busy = 1'b1;
      e_rd   = (m_t == 0);
      if (m_t >= 2) begin
        b = (m_t - 2) / C;
        if (b == 0) e_tx = 1'b0;
        else if (b <= 8) e_tx = m_byte[b-1];
        else e_tx = 1'b1;
      end
    end
    chk("cyc_tx", 32'(tx), 32'(e_tx));
    chk("cyc_busy", 32'(busy), 32'(e_busy));
    chk("cyc_fifo_rd", 32'(fifo_rd), 32'(e_rd));
    chk("cyc_tx_done", 32'(tx_done), 32'(e_done));
  end

  // ---------------- serial decoder ----------------
  logic       dec_act = 1'b0;
  int         dn = 0;
  logic [9:0] dec_bits = '0;
  logic [9:0] last_bits = '0;

  always @(negedge clk) begin
    if (rst) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (tx == 1'b0) begin
        dec_act = 1'b1;
        dn = 0;
      end
    end else begin
      dn++;
    end
    if (dec_act && !rst && (dn % C) == C / 2) begin
      dec_bits[dn / C] = tx;
      if (dn / C == 9) begin
        dec_act = 1'b0;
        last_bits = dec_bits;
        chk("start_bit", 32'(dec_bits[0]), 32'd0);
        chk("stop_bit", 32'(dec_bits[9]), 32'd1);
        dec_q.push_back(dec_bits[8:1]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc);
    int n = 0;
    while (done_cnt < target && n < maxc) begin
      step();
      n++;
    end
    chk("wait_done", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_rd(input int target, input int maxc);
    int n = 0;
    while (rd_cnt < target && n < maxc) begin
      step();
      n++;
    end
    chk("wait_rd", 32'(rd_cnt >= target), 32'd1);
  endtask

  task automatic chk_dec(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (dec_q.size() != 0) got = dec_q.pop_front();
    chk(name, 32'(got), 32'(exp));
  endtask

  initial begin
    int r0, d0, n;
    // reset values
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    rst = 1'b0;

    // empty FIFO with tx_en high
    tx_en = 1'b1;
    repeat (200) step();
    chk("empty_rd_cnt", 32'(rd_cnt), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_tx", 32'(tx), 32'd1);

    // single byte
    push(8'hA5);
    wait_done(1, 200);
    repeat (5) step();
    chk("single_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("single_bits", 32'(last_bits), 32'(10'b11_0100_1010));
    chk_dec("single_byte", 8'hA5);
    chk("single_done_lat", 32'(done_cyc[0] - rd_cyc[0]), 32'd42);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);

    // back-to-back
    r0 = rd_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_done(4, 400);
    repeat (60) step();
    chk("b2b_rd_cnt", 32'(rd_cnt - r0), 32'd3);
    chk("b2b_gap1", 32'(rd_cyc[r0+1] - rd_cyc[r0]), 32'd43);
    chk("b2b_gap2", 32'(rd_cyc[r0+2] - rd_cyc[r0+1]), 32'd43);
    chk("b2b_empty", 32'(fifo_empty), 32'd1);
    chk_dec("b2b_byte0", 8'h00);
    chk_dec("b2b_byte1", 8'hFF);
    chk_dec("b2b_byte2", 8'h3C);

    // tx_en dropped during DATA bit 3
    r0 = rd_cnt;
    d0 = done_cnt;
    push(8'h81); push(8'h7E);
    wait_rd(r0 + 1, 50);
    repeat (19) step();
    tx_en = 1'b0;
    wait_done(d0 + 1, 100);
    repeat (60) step();
    chk("txen_rd_hold", 32'(rd_cnt - r0), 32'd1);
    chk_dec("txen_byte0", 8'h81);
    tx_en = 1'b1;
    wait_done(d0 + 2, 100);
    chk_dec("txen_byte1", 8'h7E);

    // reset mid-frame
    r0 = rd_cnt;
    d0 = done_cnt;
    push(8'h55); push(8'h33);
    wait_rd(r0 + 1, 50);
    repeat (20) step();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd", 32'(fifo_rd), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done(d0 + 1, 100);
    chk("midrst_rd_cnt", 32'(rd_cnt - r0), 32'd2);
    chk_dec("midrst_byte", 8'h33);
    chk("midrst_dec_empty", 32'(dec_q.size()), 32'd0);

    // random traffic with tx_en toggling
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0 && fifo_q.size() < 4) begin
        logic [7:0] b;
        b = 8'($urandom);
        push(b);
        sent_q.push_back(b);
      end
      if ($urandom_range(0, 149) == 0) tx_en = ~tx_en;
      step();
    end
    tx_en = 1'b1;
    while ((fifo_q.size() != 0 || busy) && n < 2000) begin
      step();
      n++;
    end
    repeat (10) step();
    chk("rand_drained", 32'(n < 2000), 32'd1);
    chk("rand_count", 32'(dec_q.size()), 32'(sent_q.size()));
    while (sent_q.size() != 0) begin
      chk_dec("rand_byte", sent_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit drain stage that sits directly downstream of `fifo_top`. Whenever the FIFO holds data and transmission is enabled, it pops one byte through the FIFO read port and shifts it out as an 8N1 UART frame: one start bit, eight data bits LSB first, one stop bit. It stays idle while `fifo_empty` is high, and it never issues a read against an empty FIFO.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is ≥ 2.
- `DATA_WIDTH`, default 8: width of the FIFO word. It must match the `fifo_top` `data_out` width.
- `clk`  input  1  system clock; all logic is on the rising edge. One clock domain only.
- `rst`  input  1  asynchronous reset, active-high.
- `tx_en`  input  1  allows new frames to start. A frame already in flight always completes.
- `fifo_empty`  input  1  driven from `fifo_top.fifo_empty`.
- `fifo_data`  input  DATA_WIDTH  driven from `fifo_top.data_out`.
- `fifo_rd`  output  1  drives `fifo_top.rd`. It is a registered single-cycle pulse.
- `tx`  output  1  serial line. It idles high.
- `busy`  output  1  high in every state except IDLE.
- `tx_done`  output  1  one-cycle pulse on the cycle after the stop bit ends.

## Operation
- **States:** IDLE, FETCH, LOAD, START, DATA, STOP.
- **IDLE:** `tx=1`. If `tx_en && !fifo_empty` at a rising edge, go to FETCH. Otherwise stay in IDLE.
- **FETCH:** `fifo_rd=1` for exactly this one cycle. Go to LOAD unconditionally.
- **LOAD:** `fifo_top` presents the popped word on `data_out` after the edge that sampled `rd`. At the end of LOAD, capture `fifo_data` into the shift register, clear the baud counter and bit index, and go to START.
- **START:** `tx=0` for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** `tx = shift[0]`. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right and increment the bit index. After bit index DATA_WIDTH-1 completes, go to STOP.
- **STOP:** `tx=1` for CLKS_PER_BIT cycles, then go to IDLE with `tx_done=1` for that one IDLE cycle.
- **Baud counter:** width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at the bit boundary. The bit index is $clog2(DATA_WIDTH) bits wide.
- **`tx_en`:** sampled only in IDLE. Deasserting it during START, DATA or STOP has no effect on the current frame.
- **`fifo_empty`:** sampled only in IDLE. A change during the other states is ignored.
- **Simultaneous events:** `tx_en` rising in the same cycle that `fifo_empty` falls counts as a start condition on that edge.
- **Reset:**
  - Output values: `tx=1`, `fifo_rd=0`, `busy=0`, `tx_done=0`, state IDLE, counters 0, shift register 0.
  - Reset mid-frame forces `tx` high immediately (asynchronous) and discards the byte. The FIFO is not rewound.
- `fifo_rd` is never high while the state is anything other than FETCH.

## Timing
- Let edge k be the rising edge at which IDLE sees the start condition.
  - `fifo_rd` is high from edge k to edge k+1.
  - `tx` falls at edge k+2.
  - The stop bit ends at edge k+2+10·CLKS_PER_BIT.
  - `tx_done` is high for the cycle after that edge.
- **Back-to-back frames:** when the FIFO stays non-empty and `tx_en` stays high, the frame period is 10·CLKS_PER_BIT+3 cycles. The high time between the stop bit and the next start bit is 3 cycles (IDLE, FETCH, LOAD).
- **Latency:** from `fifo_empty` falling (with `tx_en` high and the block in IDLE) to `tx` falling is 3 edges.
- **Reset removal:** the first start condition can be sampled on the first rising edge after `rst` deasserts.

## Test plan
- **Reset values:** assert `rst` mid-cycle with any state → `tx=1`, `fifo_rd=0`, `busy=0` and `tx_done=0` immediately, without waiting for a clock edge.
- **Single byte:** CLKS_PER_BIT=4, FIFO loaded with 0xA5, `tx_en=1` → exactly one `fifo_rd` pulse. `tx` sampled every 4 cycles from its falling edge reads 0, 1,0,1,0,0,1,0,1, 1. `tx_done` pulses once, 2+40 cycles after `fifo_rd` rose.
- **Back-to-back:** CLKS_PER_BIT=4, FIFO loaded with 0x00, 0xFF, 0x3C → three `fifo_rd` pulses 43 cycles apart. The three frames decode in order to 0x00, 0xFF, 0x3C. `fifo_empty` is high after the third pop and no fourth `fifo_rd` occurs.
- **Empty FIFO:** `fifo_empty=1` and `tx_en=1` for 200 cycles → `fifo_rd` stays 0, `tx` stays 1, `busy` stays 0.
- **`tx_en` dropped mid-frame:** drop `tx_en` during DATA bit 3 of byte 0x81 with a second byte 0x7E queued → byte 0x81 completes and decodes as 0x81. No further `fifo_rd` occurs until `tx_en` returns high; then 0x7E is sent.
- **Reset mid-frame:** pulse `rst` for 1 cycle during DATA of byte 0x55 → `tx` goes high at once and `busy` goes to 0. Afterwards the next queued byte is fetched with the normal 3-edge latency and decodes correctly.
